// File: rtl/fword_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fword_sweep_ctrl
// Purpose  : DDS frequency-word sequencer. Issues either one preset word
//            (1/2/3/10 MHz) or a linear sweep from f_start to f_stop in
//            f_step increments, holding each word for 'dwell' cycles. Every
//            word is handed to the DDS through a valid/ready handshake.
// Ports    : clk, rst (sync, active-high)
//            start, abort, mode, preset_sel       - control
//            f_start, f_stop, f_step, dwell       - sweep configuration
//            fword_out, fword_valid, fword_ready  - DDS update handshake
//            busy, done                           - status
// Options  : FWORD_SWEEP_BIDIR_EN - triangle sweep (up to f_stop, then back
//            down to f_start). Undefined: sweep ends at f_stop.
// Revision : 1.0 - initial release
// ============================================================================
module fword_sweep_ctrl #(
   parameter int FW_W    = 24,
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               mode,
   input  logic [1:0]         preset_sel,
   input  logic [FW_W-1:0]    f_start,
   input  logic [FW_W-1:0]    f_stop,
   input  logic [FW_W-1:0]    f_step,
   input  logic [DWELL_W-1:0] dwell,
   output logic [FW_W-1:0]    fword_out,
   output logic               fword_valid,
   input  logic               fword_ready,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DWELL  = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [FW_W-1:0] C_PRESET_1M  = FW_W'(24'h0051EB);
   localparam logic [FW_W-1:0] C_PRESET_2M  = FW_W'(24'h00A3D7);
   localparam logic [FW_W-1:0] C_PRESET_3M  = FW_W'(24'h00F5C2);
   localparam logic [FW_W-1:0] C_PRESET_10M = FW_W'(24'h033333);

   state_t               state_q, state_d;
   logic [FW_W-1:0]      fword_q, fword_d;
   logic                 mode_q, mode_d;
   logic [FW_W-1:0]      stop_q, stop_d;
   logic [FW_W-1:0]      step_q, step_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [DWELL_W-1:0]   cnt_q, cnt_d;
   logic                 last_q, last_d;   // word currently held is the final one
   logic [FW_W:0]        nxt_up;           // extra MSB is the carry
`ifdef FWORD_SWEEP_BIDIR_EN
   logic [FW_W-1:0]      start_q, start_d;
   logic                 down_q, down_d;   // descending leg of the triangle
   logic [FW_W:0]        nxt_dn;           // extra MSB is the borrow
`endif

   function automatic logic [FW_W-1:0] preset_word(input logic [1:0] sel);
      case (sel)
         2'd0:    return C_PRESET_1M;
         2'd1:    return C_PRESET_2M;
         2'd2:    return C_PRESET_3M;
         default: return C_PRESET_10M;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         fword_q <= '0;
         mode_q  <= 1'b0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
`ifdef FWORD_SWEEP_BIDIR_EN
         start_q <= '0;
         down_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         fword_q <= fword_d;
         mode_q  <= mode_d;
         stop_q  <= stop_d;
         step_q  <= step_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
`ifdef FWORD_SWEEP_BIDIR_EN
         start_q <= start_d;
         down_q  <= down_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      fword_d = fword_q;
      mode_d  = mode_q;
      stop_d  = stop_q;
      step_d  = step_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      nxt_up  = {1'b0, fword_q} + {1'b0, step_q};
`ifdef FWORD_SWEEP_BIDIR_EN
      start_d = start_q;
      down_d  = down_q;
      nxt_dn  = {1'b0, fword_q} - {1'b0, step_q};
`endif

      case (state_q)
         IDLE: begin
            // Capture is suppressed by a simultaneous abort so the held
            // word and configuration stay untouched.
            if (start && !abort) begin
               mode_d  = mode;
               stop_d  = f_stop;
               step_d  = f_step;
               dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
               fword_d = mode ? f_start : preset_word(preset_sel);
               last_d  = (f_step == '0) || (f_start >= f_stop);
`ifdef FWORD_SWEEP_BIDIR_EN
               start_d = f_start;
               down_d  = 1'b0;
`endif
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            if (fword_ready) begin
               if (!mode_q || last_q) begin
                  state_d = FINISH;
               end else begin
                  cnt_d   = dwell_q;
                  state_d = DWELL;
               end
            end
         end

         DWELL: begin
            cnt_d = cnt_q - DWELL_W'(1);
            if (cnt_q == DWELL_W'(1)) begin
               state_d = ISSUE;
`ifdef FWORD_SWEEP_BIDIR_EN
               if (down_q) begin
                  if (nxt_dn[FW_W] || (nxt_dn[FW_W-1:0] <= start_q)) begin
                     fword_d = start_q;
                     last_d  = 1'b1;
                  end else begin
                     fword_d = nxt_dn[FW_W-1:0];
                  end
               end else
`endif
               if (nxt_up[FW_W] || (nxt_up[FW_W-1:0] >= stop_q)) begin
                  fword_d = stop_q;
`ifdef FWORD_SWEEP_BIDIR_EN
                  down_d  = 1'b1;   // top reached: turn around, not finished
`else
                  last_d  = 1'b1;
`endif
               end else begin
                  fword_d = nxt_up[FW_W-1:0];
               end
            end
         end

         FINISH: state_d = IDLE;

         default: state_d = IDLE;
      endcase

      // Abort overrides everything, including a same-cycle transfer.
      if (abort) begin
         state_d = IDLE;
      end
   end

   assign fword_out   = fword_q;
   assign fword_valid = (state_q == ISSUE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FINISH);

endmodule
`default_nettype wire

// File: tb/tb_fword_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fword_sweep_ctrl
// Purpose  : Self-checking bench for fword_sweep_ctrl. Expected word
//            sequences come from a reference sweep model and are queued at
//            start; each DDS transfer pops and compares one entry, and the
//            handshake timing is checked against the cycle of each event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fword_sweep_ctrl;
   localparam int FW = 24;
   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          rst, start, abort, mode, fword_ready;
   logic [1:0]    preset_sel;
   logic [FW-1:0] f_start, f_stop, f_step;
   logic [DW-1:0] dwell;
   logic [FW-1:0] fword_out;
   logic          fword_valid, busy, done;

   fword_sweep_ctrl #(.FW_W(FW), .DWELL_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .preset_sel(preset_sel), .f_start(f_start), .f_stop(f_stop),
      .f_step(f_step), .dwell(dwell), .fword_out(fword_out),
      .fword_valid(fword_valid), .fword_ready(fword_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   logic [FW-1:0] exp_q[$];

   // Reference sweep model: pushes every word the DDS should receive.
   task automatic push_sweep(input logic [FW-1:0] fs, input logic [FW-1:0] fp,
                             input logic [FW-1:0] st);
      logic [FW:0]   nx;
      logic [FW-1:0] cur;
      bit            fin;
      if (st == '0 || fs >= fp) begin
         exp_q.push_back(fs);
         return;
      end
      cur = fs;
      exp_q.push_back(cur);
      fin = 0;
      while (!fin) begin
         nx = {1'b0, cur} + {1'b0, st};
         if (nx[FW] || nx[FW-1:0] >= fp) begin
            exp_q.push_back(fp);
            fin = 1;
         end else begin
            cur = nx[FW-1:0];
            exp_q.push_back(cur);
         end
      end
`ifdef FWORD_SWEEP_BIDIR_EN
      cur = fp;
      fin = 0;
      while (!fin) begin
         nx = {1'b0, cur} - {1'b0, st};
         if (nx[FW] || nx[FW-1:0] <= fs) begin
            exp_q.push_back(fs);
            fin = 1;
         end else begin
            cur = nx[FW-1:0];
            exp_q.push_back(cur);
         end
      end
`endif
   endtask

   task automatic do_start(input logic m, input logic [1:0] sel,
                           input logic [FW-1:0] fs, input logic [FW-1:0] fp,
                           input logic [FW-1:0] st, input logic [DW-1:0] dw,
                           output int t);
      @(negedge clk);
      mode = m; preset_sel = sel; f_start = fs; f_stop = fp; f_step = st;
      dwell = dw; start = 1'b1; fword_ready = 1'b1;
      t = cyc;
   endtask

   // Runs one operation to completion, consuming the scoreboard.
   task automatic drain(input int t0, input int gap, input int stall_idx,
                        input int stall_len, input bit poke);
      int last_x = -10;
      int nx = 0;
      int stall_cnt = 0;
      int done_cnt = 0;
      int eg;
      bit fin = 0;
      logic [FW-1:0] exp;
      for (int i = 0; i < 3000 && !fin; i++) begin
         @(negedge clk);
         // Configuration is free to change once captured.
         start = (poke && i == 2);
         mode = 1'($urandom); preset_sel = 2'($urandom);
         f_start = FW'($urandom); f_stop = FW'($urandom); f_step = FW'($urandom);
         dwell = DW'($urandom_range(0, 7));
         fword_ready = !(nx == stall_idx && stall_cnt < stall_len);
         if (i == 0) begin
            checks++;
            if (busy !== 1'b1 || fword_valid !== 1'b1) begin
               errors++;
               $display("FAIL start_latency busy=%b valid=%b required 1/1", busy, fword_valid);
            end
         end
         if (fword_valid === 1'b1 && !fword_ready && exp_q.size() > 0) begin
            stall_cnt++;
            checks++;
            if (fword_out !== exp_q[0]) begin
               errors++;
               $display("FAIL stall_hold got %h required %h", fword_out, exp_q[0]);
            end
         end
         if (fword_valid === 1'b1 && fword_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_word got %h required none", fword_out);
            end else begin
               exp = exp_q.pop_front();
               if (fword_out !== exp) begin
                  errors++;
                  $display("FAIL word[%0d] got %h required %h", nx, fword_out, exp);
               end
            end
            checks++;
            eg = (nx == 0) ? (t0 + 1) : (last_x + gap + ((nx == stall_idx) ? stall_len : 0));
            if (cyc != eg) begin
               errors++;
               $display("FAIL xfer_time[%0d] got %0d required %0d", nx, cyc, eg);
            end
            last_x = cyc;
            nx++;
         end
         if (done === 1'b1) begin
            done_cnt++;
            checks++;
            if (cyc != last_x + 1) begin
               errors++;
               $display("FAIL done_time got %0d required %0d", cyc, last_x + 1);
            end
         end
         if (busy !== 1'b1) begin
            checks++;
            if (cyc != last_x + 2) begin
               errors++;
               $display("FAIL idle_time got %0d required %0d", cyc, last_x + 2);
            end
            fin = 1;
         end
      end
      start = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL timeout busy still %b required 0", busy);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL done_count got %0d required 1", done_cnt);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_words got %0d left required 0", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 0; abort = 0; mode = 0; preset_sel = 0;
      f_start = 0; f_stop = 0; f_step = 0; dwell = 0; fword_ready = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (fword_out !== '0 || fword_valid !== 0 || busy !== 0 || done !== 0) begin
         errors++;
         $display("FAIL reset out=%h v=%b b=%b d=%b required 0", fword_out, fword_valid, busy, done);
      end
      rst = 1'b0;
   endtask

   task automatic test_preset();
      logic [FW-1:0] tbl [4] = '{24'h0051EB, 24'h00A3D7, 24'h00F5C2, 24'h033333};
      int t;
      for (int s = 0; s < 4; s++) begin
         exp_q.push_back(tbl[s]);
         do_start(1'b0, 2'(s), 24'd5, 24'd9, 24'd1, 24'd2, t);
         drain(t, 2, -1, 0, 0);
      end
   endtask

   task automatic test_sweep();
      int t;
      push_sweep(24'd100, 24'd130, 24'd10);
      do_start(1'b1, 2'd0, 24'd100, 24'd130, 24'd10, 24'd3, t);
      drain(t, 4, -1, 0, 0);
      push_sweep(24'd100, 24'd125, 24'd10);
      do_start(1'b1, 2'd0, 24'd100, 24'd125, 24'd10, 24'd3, t);
      drain(t, 4, -1, 0, 0);
   endtask

   task automatic test_backpressure();
      int t;
      push_sweep(24'd100, 24'd130, 24'd10);
      do_start(1'b1, 2'd0, 24'd100, 24'd130, 24'd10, 24'd3, t);
      drain(t, 4, 1, 5, 0);
   endtask

   task automatic test_edges();
      int t;
      push_sweep(24'd100, 24'd130, 24'd0);
      do_start(1'b1, 2'd0, 24'd100, 24'd130, 24'd0, 24'd3, t);
      drain(t, 4, -1, 0, 0);
      push_sweep(24'd200, 24'd150, 24'd10);
      do_start(1'b1, 2'd0, 24'd200, 24'd150, 24'd10, 24'd3, t);
      drain(t, 4, -1, 0, 0);
      push_sweep(24'hFFFFF0, 24'hFFFFFF, 24'h20);
      do_start(1'b1, 2'd0, 24'hFFFFF0, 24'hFFFFFF, 24'h20, 24'd2, t);
      drain(t, 3, -1, 0, 0);
      push_sweep(24'd100, 24'd130, 24'd10);
      do_start(1'b1, 2'd0, 24'd100, 24'd130, 24'd10, 24'd0, t);
      drain(t, 2, -1, 0, 0);
   endtask

   task automatic test_back_to_back_start_ignored();
      int t;
      push_sweep(24'd100, 24'd130, 24'd10);
      do_start(1'b1, 2'd0, 24'd100, 24'd130, 24'd10, 24'd3, t);
      drain(t, 4, -1, 0, 1);
   endtask

   task automatic test_abort_dwell();
      int t;
      int bad = 0;
      do_start(1'b1, 2'd0, 24'd100, 24'd130, 24'd10, 24'd5, t);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (fword_valid !== 1'b1 || fword_out !== 24'd100) begin
         errors++;
         $display("FAIL abort_first got v=%b %h required 1 000064", fword_valid, fword_out);
      end
      @(negedge clk);
      checks++;
      if (fword_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_dwell got v=%b b=%b required 0/1", fword_valid, busy);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || fword_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got b=%b v=%b required 0/0", busy, fword_valid);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || fword_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL abort_quiet got %0d active cycles required 0", bad);
      end
   endtask

   task automatic test_start_abort_idle();
      logic [FW-1:0] prev;
      int bad = 0;
      @(negedge clk);
      prev = fword_out;
      mode = 1'b1; f_start = 24'd555; f_stop = 24'd900; f_step = 24'd1;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (busy !== 1'b0 || fword_valid !== 1'b0 || done !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL start_abort_idle got %0d active cycles required 0", bad);
      end
      checks++;
      if (fword_out !== prev) begin
         errors++;
         $display("FAIL start_abort_word got %h required %h", fword_out, prev);
      end
   endtask

   task automatic test_reset_mid();
      int t;
      do_start(1'b1, 2'd0, 24'd100, 24'd130, 24'd10, 24'd3, t);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (fword_out !== '0 || fword_valid !== 0 || busy !== 0 || done !== 0) begin
         errors++;
         $display("FAIL reset_mid out=%h v=%b b=%b d=%b required 0", fword_out, fword_valid, busy, done);
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_preset();
      test_sweep();
      test_backpressure();
      test_edges();
      test_back_to_back_start_ignored();
      test_abort_dwell();
      test_start_abort_idle();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
